// File: rtl/wb_dma_engine_if.sv
// Wishbone bus bundle between the DMA initiator and the SDRAM arbiter's DMA port.
interface wb_dma_engine_if;
    logic        dma_cyc_o;
    logic        dma_stb_o;
    logic        dma_we_o;
    logic [3:0]  dma_sel_o;
    logic [31:0] dma_adr_o;
    logic [31:0] dma_dat_o;
    logic        dma_ack_i;
    logic [31:0] dma_dat_i;

    modport master (
        output dma_cyc_o, dma_stb_o, dma_we_o, dma_sel_o, dma_adr_o, dma_dat_o,
        input  dma_ack_i, dma_dat_i
    );

    modport slave (
        input  dma_cyc_o, dma_stb_o, dma_we_o, dma_sel_o, dma_adr_o, dma_dat_o,
        output dma_ack_i, dma_dat_i
    );
endinterface

// File: rtl/wb_dma_engine.sv
// Wishbone DMA block copier: alternating single-word read/write with an idle
// bus cycle after every ack so the CPU can win arbitration.
module wb_dma_engine #(
    parameter int unsigned ADDR_STEP      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] xfer_count,
    wb_dma_engine_if.master dma
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE, ERR
    } state_t;

    state_t         state, state_next;
    logic [31:0]    src, dst, adr, buffer;
    logic [15:0]    remaining;
    logic [TW-1:0]  tmo;
    logic           cyc, we;
    logic           tmo_last;

    assign tmo_last      = (tmo == TW'(TIMEOUT_CYCLES - 1));
    assign dma.dma_cyc_o = cyc;
    assign dma.dma_stb_o = cyc;
    assign dma.dma_we_o  = we;
    assign dma.dma_sel_o = 4'hF;
    assign dma.dma_adr_o = adr;
    assign dma.dma_dat_o = buffer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len != 16'd0) ? RD_REQ : DONE;
            RD_REQ: begin
                if (dma.dma_ack_i)  state_next = RD_GAP;
                else if (tmo_last)  state_next = ERR;
            end
            RD_GAP:  state_next = WR_REQ;
            WR_REQ: begin
                if (dma.dma_ack_i)  state_next = (remaining == 16'd1) ? DONE : WR_GAP;
                else if (tmo_last)  state_next = ERR;
            end
            WR_GAP:  state_next = RD_REQ;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing combinational reaches the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cyc        <= 1'b0;
            we         <= 1'b0;
            adr        <= '0;
            buffer     <= '0;
            src        <= '0;
            dst        <= '0;
            remaining  <= '0;
            xfer_count <= '0;
            tmo        <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            err  <= (state_next == ERR);
            cyc  <= (state_next == RD_REQ) || (state_next == WR_REQ);
            we   <= (state_next == WR_REQ);
            tmo  <= ((state_next == state) && (state == RD_REQ || state == WR_REQ))
                    ? tmo + 1'b1 : '0;
            case (state)
                IDLE: if (start) begin
                    src        <= src_addr;
                    dst        <= dst_addr;
                    remaining  <= len;
                    xfer_count <= '0;
                    adr        <= src_addr;
                end
                RD_REQ: if (dma.dma_ack_i) begin
                    buffer <= dma.dma_dat_i;
                    src    <= src + 32'(ADDR_STEP);
                end
                RD_GAP: adr <= dst;
                WR_REQ: if (dma.dma_ack_i) begin
                    dst        <= dst + 32'(ADDR_STEP);
                    xfer_count <= xfer_count + 16'd1;
                    remaining  <= remaining - 16'd1;
                end
                WR_GAP: adr <= src;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_engine.sv
// Directed bench for wb_dma_engine: memory responder with programmable wait
// states and a read-ack cutoff, plus bus-rule monitors.
module tb_wb_dma_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [15:0] xfer_count;

    wb_dma_engine_if bus ();

    wb_dma_engine #(.ADDR_STEP(4), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .xfer_count (xfer_count),
        .dma        (bus.master)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Responder: ack after `waits` stalled cycles; reads beyond rd_limit are never acked.
    logic [31:0] mem [256];
    int          waits = 0;
    int          wcnt = 0;
    int          rd_cnt = 0;
    int          rd_limit = 1000000;
    logic        ack;
    logic [31:0] rd_q[$];
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];

    assign ack = bus.dma_stb_o && (wcnt == waits) && (bus.dma_we_o || rd_cnt < rd_limit);
    assign bus.dma_ack_i = ack;
    assign bus.dma_dat_i = mem[bus.dma_adr_o[9:2]];

    always @(posedge clk) begin
        if (!bus.dma_stb_o || ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
        if (bus.dma_cyc_o && bus.dma_stb_o && ack) begin
            if (bus.dma_we_o) begin
                mem[bus.dma_adr_o[9:2]] <= bus.dma_dat_o;
                wr_adr_q.push_back(bus.dma_adr_o);
                wr_dat_q.push_back(bus.dma_dat_o);
            end else begin
                rd_q.push_back(bus.dma_adr_o);
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // Bus-rule monitors: idle cycle after ack, stable request, stb count.
    int          gap_viol = 0;
    int          stab_viol = 0;
    int          stb_cnt = 0;
    logic        p_stb = 1'b0, p_ack = 1'b0;
    logic [31:0] p_adr = '0, p_dat = '0;

    always @(negedge clk) begin
        if (bus.dma_stb_o) stb_cnt <= stb_cnt + 1;
        if (p_stb && p_ack && bus.dma_stb_o) gap_viol <= gap_viol + 1;
        if (p_stb && !p_ack && bus.dma_stb_o &&
            (bus.dma_adr_o != p_adr || (bus.dma_we_o && bus.dma_dat_o != p_dat)))
            stab_viol <= stab_viol + 1;
        p_stb <= bus.dma_stb_o;
        p_ack <= ack;
        p_adr <= bus.dma_adr_o;
        p_dat <= bus.dma_dat_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_adr_q.delete();
        wr_dat_q.delete();
        stb_cnt = 0;
        gap_viol = 0;
        stab_viol = 0;
    endtask

    // Leaves the bench #1 after the accepting edge, i.e. in cycle 1.
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        clear_logs();
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Steps cycles until done or err (bounded); optionally pokes start at cycle `poke`.
    task automatic run(input int max, input int poke, output int dc, output int ec);
        dc = 0; ec = 0;
        for (int c = 1; c <= max; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            if (c == poke) begin
                src_addr = 32'h3F0; dst_addr = 32'h7F0; len = 16'd1; start = 1'b1;
            end
            if (done && dc == 0) dc = c;
            if (err && ec == 0) ec = c;
            if (dc != 0 || ec != 0) break;
        end
        start = 1'b0;
    endtask

    int dc, ec;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64] = 32'hA; mem[65] = 32'hB; mem[66] = 32'hC; mem[67] = 32'hD;
        mem[192] = 32'h55; mem[193] = 32'h66;
        mem[255] = 32'h11; mem[0] = 32'h22;

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_cyc_stb_we", {29'd0, bus.dma_cyc_o, bus.dma_stb_o, bus.dma_we_o}, 32'd0);
        check("rst_sel", 32'(bus.dma_sel_o), 32'hF);
        check("rst_adr", bus.dma_adr_o, 32'd0);
        check("rst_dat", bus.dma_dat_o, 32'd0);
        check("rst_xfer", 32'(xfer_count), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // len=3, zero wait
        start_xfer(32'h100, 32'h200, 16'd3);
        check("l3_stb_c1", 32'(bus.dma_stb_o), 32'd1);
        run(40, 0, dc, ec);
        check("l3_done_cycle", dc, 32'd12);
        check("l3_xfer", 32'(xfer_count), 32'd3);
        check("l3_nwr", wr_adr_q.size(), 32'd3);
        if (wr_adr_q.size() == 3) begin
            check("l3_wr0", {wr_adr_q[0][15:0], wr_dat_q[0][15:0]}, 32'h0200_000A);
            check("l3_wr1", {wr_adr_q[1][15:0], wr_dat_q[1][15:0]}, 32'h0204_000B);
            check("l3_wr2", {wr_adr_q[2][15:0], wr_dat_q[2][15:0]}, 32'h0208_000C);
        end
        check("l3_stb_cnt", stb_cnt, 32'd6);
        @(posedge clk); #1;
        check("l3_busy_after", {30'd0, busy, done}, 32'd0);

        // len=2, ack on 3rd cycle of every request
        waits = 2;
        start_xfer(32'h300, 32'h380, 16'd2);
        run(40, 0, dc, ec);
        check("w2_done_cycle", dc, 32'd16);
        check("w2_stb_cnt", stb_cnt, 32'd12);
        check("w2_gap_viol", gap_viol, 32'd0);
        check("w2_stab_viol", stab_viol, 32'd0);
        check("w2_wr1", wr_dat_q.size() == 2 ? wr_dat_q[1] : 32'hX, 32'h66);
        check("w2_mem", mem[225], 32'h66);
        waits = 0;
        @(posedge clk); #1;

        // len=0: done in cycle 1, no bus activity
        start_xfer(32'h100, 32'h200, 16'd0);
        run(5, 0, dc, ec);
        check("l0_done_cycle", dc, 32'd1);
        check("l0_busy", 32'(busy), 32'd1);
        check("l0_xfer", 32'(xfer_count), 32'd0);
        @(posedge clk); #1;
        check("l0_stb_cnt", stb_cnt, 32'd0);

        // len=4 with a start poked in while busy
        start_xfer(32'h100, 32'h240, 16'd4);
        run(40, 3, dc, ec);
        check("l4_done_cycle", dc, 32'd16);
        check("l4_xfer", 32'(xfer_count), 32'd4);
        check("l4_last_wr", wr_adr_q.size() == 4 ? wr_adr_q[3] : 32'hX, 32'h24C);
        check("l4_last_dat", wr_dat_q.size() == 4 ? wr_dat_q[3] : 32'hX, 32'hD);
        check("l4_gap_viol", gap_viol, 32'd0);
        @(posedge clk); #1;

        // Timeout on the second read
        rd_limit = rd_cnt + 1;
        start_xfer(32'h100, 32'h280, 16'd2);
        run(40, 0, dc, ec);
        check("to_err_cycle", ec, 32'd13);
        check("to_no_done", dc, 32'd0);
        check("to_xfer", 32'(xfer_count), 32'd1);
        check("to_stb_cnt", stb_cnt, 32'd10);
        check("to_stb_in_err", 32'(bus.dma_stb_o), 32'd0);
        @(posedge clk); #1;
        check("to_after", {29'd0, busy, done, err}, 32'd0);
        rd_limit = 1000000;

        // Source address wrap
        start_xfer(32'hFFFF_FFFC, 32'h5C0, 16'd2);
        run(40, 0, dc, ec);
        check("wr_done_cycle", dc, 32'd8);
        check("wrap_rd1_adr", rd_q.size() == 2 ? rd_q[1] : 32'hX, 32'h0);
        check("wrap_wr1_dat", wr_dat_q.size() == 2 ? wr_dat_q[1] : 32'hX, 32'h22);
        @(posedge clk); #1;

        // Reset during WR_REQ of word 2 (cycle 7)
        start_xfer(32'h100, 32'h600, 16'd3);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("rs_in_wr2", {30'd0, bus.dma_stb_o, bus.dma_we_o}, 32'd3);
        rst = 1'b1;
        #1;
        check("rs_immediate", {29'd0, bus.dma_cyc_o, bus.dma_stb_o, busy}, 32'd0);
        @(posedge clk); #1;
        check("rs_next", {29'd0, bus.dma_cyc_o, bus.dma_stb_o, busy}, 32'd0);
        check("rs_xfer", 32'(xfer_count), 32'd0);
        check("rs_nwr", wr_adr_q.size(), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        start_xfer(32'h100, 32'h700, 16'd1);
        run(20, 0, dc, ec);
        check("rs_rerun_done", dc, 32'd4);
        check("rs_rerun_wr", wr_dat_q.size() == 1 ? wr_dat_q[0] : 32'hX, 32'hA);
        check("rs_rerun_xfer", 32'(xfer_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/wb_dma_engine.md
# wb_dma_engine

Wishbone DMA initiator that copies a block of 32-bit words from a source address to a destination address in SDRAM. It drives the DMA master port of the CPU/DMA SDRAM arbiter and acts as the initiator that port serves. The engine alternates single-word reads and writes. It inserts one idle bus cycle after every acknowledged transaction so a pending CPU request can win arbitration.

## Interface
Parameters:
- ADDR_STEP, 4: byte increment applied to both addresses after each word.
- TIMEOUT_CYCLES, 1024: maximum number of cycles a request may wait for ack before the transfer aborts.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a transfer; sampled only in IDLE.
- src_addr  in  32  source byte address, captured on an accepted start.
- dst_addr  in  32  destination byte address, captured on an accepted start.
- len  in  16  number of words to copy, captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE/ERR cycle.
- done  out  1  one-cycle pulse when all words have been written.
- err  out  1  one-cycle pulse when the transfer aborts on timeout.
- xfer_count  out  16  number of words written in the current or last transfer.
- dma_cyc_o, dma_stb_o  out  1  Wishbone cycle and strobe; always driven equal.
- dma_we_o  out  1  0 for a read, 1 for a write.
- dma_sel_o  out  4  byte selects; always 4'hF.
- dma_adr_o  out  32  bus address.
- dma_dat_o  out  32  write data.
- dma_ack_i  in  1  acknowledge; may arrive in the same cycle as stb.
- dma_dat_i  in  32  read data; valid when ack is high during a read.

## Operation
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE, ERR.
- IDLE, start=1, len≠0: capture src, dst and len, clear xfer_count, go to RD_REQ.
- IDLE, start=1, len=0: go to DONE with no bus activity; xfer_count is cleared to 0.
- IDLE, start=0: stay in IDLE.
- RD_REQ: drive cyc=stb=1, we=0, adr=src.
  - On ack: latch dma_dat_i into the data buffer, add ADDR_STEP to src, go to RD_GAP.
- RD_GAP: drive cyc=stb=0 for one cycle, then go to WR_REQ.
- WR_REQ: drive cyc=stb=1, we=1, adr=dst, dat=buffer.
  - On ack: add ADDR_STEP to dst, increment xfer_count, decrement the remaining count.
  - If the remaining count becomes 0, go to DONE; otherwise go to WR_GAP.
- WR_GAP: drive cyc=stb=0 for one cycle, then go to RD_REQ.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- ERR: err=1 and busy=1 for one cycle, then go to IDLE. xfer_count holds the number of words written before the abort.
- Timeout counter:
  - Cleared on entry to RD_REQ or WR_REQ; increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, drop cyc and stb on the next edge and go to ERR.
- Address arithmetic is modulo 2^32; wrap-around is silent.
- start while busy is ignored; the captured parameters are not disturbed.
- dma_ack_i is ignored in every state except RD_REQ and WR_REQ.
- rst asserted at any time, including mid-transfer:
  - all state and outputs return to reset values immediately;
  - no partial write completes.

## Timing
- Reset values:
  - state IDLE; busy, done, err, dma_cyc_o, dma_stb_o, dma_we_o all 0;
  - dma_sel_o 4'hF; dma_adr_o, dma_dat_o, xfer_count all 0.
- All outputs are registered; no combinational path from ack to any output.
- Start accepted at edge N: stb is high during cycle N+1.
- Zero-wait acks, 4 cycles per word: RD, RD_GAP, WR, WR_GAP. The last word ends with WR followed by DONE.
- len=1 with zero-wait acks, start at edge 0:
  - cycle 1 read; cycle 2 gap; cycle 3 write; cycle 4 done=1; cycle 5 busy=0.
- len=L with zero-wait acks: done occurs 4L cycles after the accepting edge.
- Each wait state on an ack adds exactly one cycle.
- After every ack, cyc and stb are low for at least one full cycle before the next request.
- Address and data are stable for the whole of every request.

## Test plan
- len=3, src=0x100, dst=0x200, zero-wait responder preloaded with 0xA,0xB,0xC:
  - writes 0xA@0x200, 0xB@0x204, 0xC@0x208;
  - done in cycle 12; xfer_count=3.
- len=2 with a 3-cycle ack delay on every access:
  - each request is held with constant address and data until ack;
  - done in cycle 16; stb is low for ≥1 cycle between all four accesses.
- len=0: done pulse in cycle 1 with no stb at all; a start during busy of a len=4 run has no effect.
- TIMEOUT_CYCLES=8, no ack on the second read:
  - stb drops after 8 cycles; err pulses; done never pulses;
  - xfer_count=1; busy=0 the following cycle.
- src=0xFFFFFFFC, len=2: second read address is 0x00000000.
- rst asserted during WR_REQ of word 2: next cycle stb=cyc=0, busy=0, xfer_count=0; a new start afterwards runs normally.
